// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for the execute stage: iterative 32-step multiply/divide,
// MTHI/MTLO writes, and pipeline stall while an operation is in flight.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mf_req,
  output logic        busy,
  output logic        stall,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_d,
  output logic [31:0] lo_d
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_WB} state_t;

  state_t      state_q;
  logic        busy_q;
  logic        hi_we_q, lo_we_q;
  logic [31:0] hi_d_q, lo_d_q;
  logic        is_div_q, neg_res_q, neg_rem_q;
  logic [31:0] opnd_q;   // |multiplicand| for MUL, |divisor| for DIV
  logic [63:0] acc_q;    // {partial product, multiplier} or {remainder, dividend/quotient}
  logic [4:0]  cnt_q;

  logic        op_signed;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_signed = ~op[0];

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    mul_next = {mul_sum, acc_q[31:1]};
    // Restoring step: the shifted remainder is below 2*divisor, so the
    // difference always fits in 32 bits when it is kept.
    div_ge   = acc_q[63:31] >= {1'b0, opnd_q};
    div_diff = acc_q[62:31] - opnd_q;
    if (div_ge) div_next = {div_diff, acc_q[30:0], 1'b1};
    else        div_next = {acc_q[62:31], acc_q[30:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      hi_we_q   <= 1'b0;
      lo_we_q   <= 1'b0;
      hi_d_q    <= 32'd0;
      lo_d_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 5'd0;
    end else begin
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                state_q   <= S_MUL;
                busy_q    <= 1'b1;
                is_div_q  <= 1'b0;
                cnt_q     <= 5'd0;
                opnd_q    <= mag32(a, op_signed);
                acc_q     <= {32'd0, mag32(b, op_signed)};
                neg_res_q <= op_signed & (a[31] ^ b[31]);
                neg_rem_q <= 1'b0;
              end
              3'b010, 3'b011: begin
                busy_q <= 1'b1;
                if (b == 32'd0) begin
                  state_q <= S_WB;
                  hi_we_q <= 1'b1;
                  lo_we_q <= 1'b1;
                  hi_d_q  <= a;
                  lo_d_q  <= 32'hFFFF_FFFF;
                end else begin
                  state_q   <= S_DIV;
                  is_div_q  <= 1'b1;
                  cnt_q     <= 5'd0;
                  opnd_q    <= mag32(b, op_signed);
                  acc_q     <= {32'd0, mag32(a, op_signed)};
                  neg_res_q <= op_signed & (a[31] ^ b[31]);
                  neg_rem_q <= op_signed & a[31];
                end
              end
              3'b100: begin
                state_q <= S_WB;
                busy_q  <= 1'b1;
                hi_we_q <= 1'b1;
                hi_d_q  <= a;
              end
              3'b101: begin
                state_q <= S_WB;
                busy_q  <= 1'b1;
                lo_we_q <= 1'b1;
                lo_d_q  <= a;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            hi_d_q <= cneg32(acc_q[63:32], neg_rem_q);
            lo_d_q <= cneg32(acc_q[31:0], neg_res_q);
          end else begin
            {hi_d_q, lo_d_q} <= cneg64(acc_q, neg_res_q);
          end
          hi_we_q <= 1'b1;
          lo_we_q <= 1'b1;
          state_q <= S_WB;
        end
        S_WB: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q & (start | mf_req);
  assign hi_we = hi_we_q;
  assign lo_we = lo_we_q;
  assign hi_d  = hi_d_q;
  assign lo_d  = lo_d_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed + randomized bench for muldiv_ctrl, checked against an arithmetic
// reference model of the HI/LO results and cycle timing.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        mf_req;
  logic        busy, stall, hi_we, lo_we;
  logic [31:0] hi_d, lo_d;

  int total = 0;
  int bad   = 0;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mf_req(mf_req), .busy(busy), .stall(stall), .hi_we(hi_we),
    .lo_we(lo_we), .hi_d(hi_d), .lo_d(lo_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain 64-bit arithmetic, latency from the op class.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic ehw, output logic elw, output int lat);
    longint          sp, sq, sr;
    logic [63:0]     up;
    eh = 32'd0; el = 32'd0; ehw = 1'b1; elw = 1'b1; lat = 34;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        up = sp;
        eh = up[63:32]; el = up[31:0];
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        eh = up[63:32]; el = up[31:0];
      end
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFF_FFFF; lat = 1;
        end else if (o == 3'd2) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          up = sq; el = up[31:0];
          up = sr; eh = up[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
      end
      3'd4: begin eh = x; elw = 1'b0; lat = 1; end
      default: begin el = x; ehw = 1'b0; lat = 1; end
    endcase
  endtask

  // Issue one op at the current cycle and watch it through to IDLE.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    logic [31:0] eh, el, hd, ld;
    logic        ehw, elw, hw, lw;
    int          lat, busy_n, we_n, we_at;
    model(o, x, y, eh, el, ehw, elw, lat);
    check({tag, " idle-before"}, busy, 0);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111;
    busy_n = 0; we_n = 0; we_at = 0; hw = 0; lw = 0; hd = 0; ld = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (!busy) break;
      busy_n++;
      if (hi_we || lo_we) begin
        we_n++; we_at = n; hw = hi_we; lw = lo_we; hd = hi_d; ld = lo_d;
      end
    end
    @(posedge clk); #1;
    check({tag, " busy-cycles"}, busy_n, lat);
    check({tag, " we-pulses"}, we_n, 1);
    check({tag, " we-cycle"}, we_at, lat);
    check({tag, " hi_we"}, hw, ehw);
    check({tag, " lo_we"}, lw, elw);
    if (ehw) check({tag, " hi_d"}, hd, eh);
    if (elw) check({tag, " lo_d"}, ld, el);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry, eh, el, hd, ld;
    logic        ehw, elw;
    int          lat, we_n, we_at, act_n;

    reset = 1'b1; start = 1'b0; op = 3'b111; a = 0; b = 0; mf_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset we", {hi_we, lo_we}, 0);
    check("reset data", {hi_d, lo_d}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("multu ffffffff*2", 3'd1, 32'hFFFF_FFFF, 32'd2);
    run_op("mult -3*5",        3'd0, -32'sd3, 32'd5);
    run_op("mult min*min",     3'd0, 32'h8000_0000, 32'h8000_0000);
    run_op("div -7/2",         3'd2, -32'sd7, 32'd2);
    run_op("divu 7/2",         3'd3, 32'd7, 32'd2);
    run_op("div min/-1",       3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu 5/0",         3'd3, 32'd5, 32'd0);
    run_op("div -9/0",         3'd2, -32'sd9, 32'd0);
    run_op("mthi",             3'd4, 32'h1234_5678, 32'd0);
    run_op("mtlo",             3'd5, 32'hCAFE_F00D, 32'd0);
    run_op("div 7/-2",         3'd2, 32'd7, -32'sd2);

    // Nop ops are not accepted.
    op = 3'b110; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111;
    check("nop no-busy", busy, 0);

    // MULT with mf_req held from C+1 and a stray start at C+5.
    model(3'd0, -32'sd3, 32'd5, eh, el, ehw, elw, lat);
    op = 3'd0; a = -32'sd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mf_req = 1'b1;
    we_n = 0; we_at = 0; hd = 0; ld = 0;
    for (int n = 1; n <= 35; n++) begin
      if (n == 5) begin start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; end
      else start = 1'b0;
      @(negedge clk);
      check($sformatf("stall c+%0d", n), stall, (n <= 34));
      if (hi_we || lo_we) begin we_n++; we_at = n; hd = hi_d; ld = lo_d; end
      @(posedge clk); #1;
    end
    start = 1'b0; mf_req = 1'b0; op = 3'b111;
    check("stall we-pulses", we_n, 1);
    check("stall we-cycle", we_at, 34);
    check("stall hi_d", hd, eh);
    check("stall lo_d", ld, el);
    check("stall idle-after", busy, 0);

    // Reset in C+10 of a DIV.
    op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111;
    repeat (9) @(posedge clk);
    #1;
    check("pre-reset busy", busy, 1);
    reset = 1'b1;
    #1;
    check("async reset busy", busy, 0);
    check("async reset we", {hi_we, lo_we}, 0);
    check("async reset data", {hi_d, lo_d}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    act_n = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy || hi_we || lo_we) act_n++;
    end
    @(posedge clk); #1;
    check("post-reset quiet", act_n, 0);
    run_op("multu after reset", 3'd1, 32'd123456, 32'd654321);

    // Randomized ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 5));
      rx = $urandom;
      case ($urandom_range(0, 4))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 20));
        2:       ry = -32'($urandom_range(1, 20));
        default: ry = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, ro), ro, rx, ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
